// File: rtl/wos_filter_sequencer_if.sv
// wos_filter_sequencer_if: valid/ready sample stream, used for both the
// sequencer's input (slave side) and its output (master side).
interface wos_filter_sequencer_if #(
  parameter int W = 8
) ();
  logic [W-1:0] data;
  logic         valid;
  logic         ready;

  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/wos_filter_sequencer.sv
// wos_filter_sequencer: program table and burst sequencer for the masked rank-order filter core.
// Optional define WOS_SEQ_PAD_EN: warm-up outputs from the zero-filled window are emitted too.
module wos_filter_sequencer #(
  parameter int  N         = 11,
  parameter int  DATA_BITS = 8,
  parameter int  PROGS     = 4,
  parameter int  LAT       = 2,
  parameter int  CNT_BITS  = 16,
  localparam int AW        = (PROGS > 1) ? $clog2(PROGS) : 1,
  localparam int RW        = $clog2(N + 1),
  localparam int DW        = (LAT > 1) ? $clog2(LAT) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cfg_we,
  input  logic [AW-1:0]          cfg_addr,
  input  logic [N-1:0]           cfg_mask,
  input  logic [RW-1:0]          cfg_rank,
  input  logic                   start,
  input  logic [AW-1:0]          prog_sel,
  input  logic [CNT_BITS-1:0]    num_samples,
  output logic                   busy,
  output logic                   done,
  output logic                   cfg_err,
  wos_filter_sequencer_if.slave  s,
  output logic [DATA_BITS-1:0]   f_in,
  output logic [N-1:0]           f_mask,
  output logic [RW-1:0]          f_rank,
  output logic                   f_en,
  output logic                   f_clr,
  input  logic [DATA_BITS-1:0]   f_out,
  wos_filter_sequencer_if.master m
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_RUN   = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  localparam logic [CNT_BITS-1:0] CNT_ONE  = CNT_BITS'(1);
  localparam logic [RW-1:0]       RANK_DEF = RW'(N / 2 + 1);

  function automatic logic [RW-1:0] popcount(input logic [N-1:0] v);
    logic [RW-1:0] c;
    c = {RW{1'b0}};
    for (int i = 0; i < N; i++) begin
      c = c + RW'(v[i]);
    end
    return c;
  endfunction

  state_t                 state_r, state_nx_s;
  logic [N-1:0]           tbl_mask_r [PROGS];
  logic [RW-1:0]          tbl_rank_r [PROGS];
  logic [AW-1:0]          prog_r;
  logic [CNT_BITS-1:0]    num_r;
  logic [CNT_BITS-1:0]    in_cnt_r;
  logic [DW-1:0]          drain_cnt_r;
  logic [N-1:0]           act_mask_r;
  logic [RW-1:0]          act_rank_r;
  logic                   cfg_err_r;
  logic [LAT-1:0]         tag_r;
  logic [DATA_BITS-1:0]   m_data_r;
  logic                   m_valid_r;
  logic [N-1:0]           sel_mask_s;
  logic [RW-1:0]          sel_rank_s;
  logic                   cfg_bad_s;
  logic                   adv_s;
  logic                   s_ready_s;
  logic                   tag_in_s;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Program table; writable in any state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int p = 0; p < PROGS; p++) begin
        tbl_mask_r[p] <= {N{1'b1}};
        tbl_rank_r[p] <= RANK_DEF;
      end
    end else if (cfg_we) begin
      tbl_mask_r[cfg_addr] <= cfg_mask;
      tbl_rank_r[cfg_addr] <= cfg_rank;
    end
  end

  // Next state, stream handshake and core enable
  always_comb begin
    state_nx_s = state_r;
    adv_s      = 1'b0;
    s_ready_s  = 1'b0;
    tag_in_s   = 1'b0;
    sel_mask_s = tbl_mask_r[prog_r];
    sel_rank_s = tbl_rank_r[prog_r];
    cfg_bad_s  = (sel_rank_s == {RW{1'b0}}) || (sel_rank_s > popcount(sel_mask_s));
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_nx_s = ST_LOAD;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_LOAD: begin
        if (cfg_bad_s) begin
          state_nx_s = ST_DONE;
        end else if (num_r == {CNT_BITS{1'b0}}) begin
          state_nx_s = ST_DONE;
        end else begin
          state_nx_s = ST_RUN;
        end
      end
      ST_RUN: begin
        adv_s     = s.valid && (!m_valid_r || m.ready);
        s_ready_s = adv_s;
`ifdef WOS_SEQ_PAD_EN
        tag_in_s  = 1'b1;
`else
        tag_in_s  = (in_cnt_r >= CNT_BITS'(N - 1));
`endif
        if (adv_s && (in_cnt_r == num_r - CNT_ONE)) begin
          state_nx_s = ST_DRAIN;
        end else begin
          state_nx_s = ST_RUN;
        end
      end
      ST_DRAIN: begin
        adv_s = !m_valid_r || m.ready;
        if (adv_s && (drain_cnt_r == DW'(LAT - 1))) begin
          state_nx_s = ST_DONE;
        end else begin
          state_nx_s = ST_DRAIN;
        end
      end
      ST_DONE: begin
        state_nx_s = ST_IDLE;
      end
      default: begin
        state_nx_s = ST_IDLE;
      end
    endcase
  end

  // Run context: latched program, sample/drain counters, config error flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prog_r      <= {AW{1'b0}};
      num_r       <= {CNT_BITS{1'b0}};
      in_cnt_r    <= {CNT_BITS{1'b0}};
      drain_cnt_r <= {DW{1'b0}};
      act_mask_r  <= {N{1'b0}};
      act_rank_r  <= {RW{1'b0}};
      cfg_err_r   <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            prog_r    <= prog_sel;
            num_r     <= num_samples;
            cfg_err_r <= 1'b0;
          end
        end
        ST_LOAD: begin
          act_mask_r  <= sel_mask_s;
          act_rank_r  <= sel_rank_s;
          in_cnt_r    <= {CNT_BITS{1'b0}};
          drain_cnt_r <= {DW{1'b0}};
          cfg_err_r   <= cfg_bad_s;
        end
        ST_RUN: begin
          if (adv_s) begin
            in_cnt_r <= in_cnt_r + CNT_ONE;
          end
        end
        ST_DRAIN: begin
          if (adv_s) begin
            drain_cnt_r <= drain_cnt_r + DW'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Tag pipeline mirrors the core latency so results line up with their tags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag_r <= {LAT{1'b0}};
    end else if (state_r == ST_LOAD) begin
      tag_r <= {LAT{1'b0}};
    end else if (adv_s) begin
      tag_r[0] <= tag_in_s;
      for (int i = 1; i < LAT; i++) begin
        tag_r[i] <= tag_r[i - 1];
      end
    end
  end

  // Output register; only loaded on an enabled cycle, so nothing is overwritten while stalled
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_data_r  <= {DATA_BITS{1'b0}};
      m_valid_r <= 1'b0;
    end else if (adv_s && tag_r[LAT-1]) begin
      m_data_r  <= f_out;
      m_valid_r <= 1'b1;
    end else if (m.ready) begin
      m_valid_r <= 1'b0;
    end
  end

  assign busy    = (state_r != ST_IDLE);
  assign done    = (state_r == ST_DONE);
  assign cfg_err = cfg_err_r;
  assign f_clr   = (state_r == ST_LOAD);
  assign f_en    = adv_s;
  assign f_in    = (state_r == ST_RUN) ? s.data : {DATA_BITS{1'b0}};
  assign f_mask  = (state_r == ST_LOAD) ? sel_mask_s : act_mask_r;
  assign f_rank  = (state_r == ST_LOAD) ? sel_rank_s : act_rank_r;
  assign s.ready = s_ready_s;
  assign m.data  = m_data_r;
  assign m.valid = m_valid_r;

endmodule

// File: tb/tb_wos_filter_sequencer.sv
// tb_wos_filter_sequencer: randomized bench with a behavioural filter core and an
// array-based reference of the expected output stream per run.
module tb_wos_filter_sequencer;

  localparam int N     = 11;
  localparam int DB    = 8;
  localparam int PROGS = 4;
  localparam int LAT   = 2;
`ifdef WOS_SEQ_PAD_EN
  localparam int FIRST = 0;
`else
  localparam int FIRST = N - 1;
`endif

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           cfg_we = 1'b0;
  logic [1:0]     cfg_addr = 2'd0;
  logic [N-1:0]   cfg_mask = '0;
  logic [3:0]     cfg_rank = 4'd0;
  logic           start = 1'b0;
  logic [1:0]     prog_sel = 2'd0;
  logic [15:0]    num_samples = 16'd0;
  logic           busy, done, cfg_err;
  logic [DB-1:0]  f_in, f_out;
  logic [N-1:0]   f_mask;
  logic [3:0]     f_rank;
  logic           f_en, f_clr;

  wos_filter_sequencer_if #(.W(DB)) s_if ();
  wos_filter_sequencer_if #(.W(DB)) m_if ();

  wos_filter_sequencer dut (
    .clk(clk), .rst(rst),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_mask(cfg_mask), .cfg_rank(cfg_rank),
    .start(start), .prog_sel(prog_sel), .num_samples(num_samples),
    .busy(busy), .done(done), .cfg_err(cfg_err),
    .s(s_if.slave),
    .f_in(f_in), .f_mask(f_mask), .f_rank(f_rank), .f_en(f_en), .f_clr(f_clr), .f_out(f_out),
    .m(m_if.master)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Rank-th smallest of the masked taps
  function automatic logic [DB-1:0] wos_pick(input logic [DB-1:0] w [N], input logic [N-1:0] mk, input int rk);
    logic [DB-1:0] v [$];
    for (int i = 0; i < N; i++) if (mk[i]) v.push_back(w[i]);
    v.sort();
    if (rk < 1 || rk > v.size()) return '0;
    return v[rk - 1];
  endfunction

  // Behavioural core: window register then result register, both gated by f_en
  logic [DB-1:0] win [N];
  logic [DB-1:0] res;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N; i++) win[i] <= '0;
      res <= '0;
    end else if (f_clr) begin
      for (int i = 0; i < N; i++) win[i] <= '0;
    end else if (f_en) begin
      res    <= wos_pick(win, f_mask, int'(f_rank));
      win[0] <= f_in;
      for (int i = 1; i < N; i++) win[i] <= win[i - 1];
    end
  end
  assign f_out = res;

  logic [N-1:0]  sh_mask [PROGS];
  int            sh_rank [PROGS];
  logic [DB-1:0] smp_q [$];
  logic [DB-1:0] exp_q [$];
  logic [DB-1:0] got_q [$];
  int            got_it_q [$];
  int            sready_seen, mvalid_seen;

  function automatic void build_exp(input logic [N-1:0] mk, input int rk, input int n);
    logic [DB-1:0] w [N];
    exp_q.delete();
    if (rk < 1 || rk > $countones(mk)) return;
    for (int j = FIRST; j < n; j++) begin
      for (int i = 0; i < N; i++) w[i] = (j - i >= 0) ? smp_q[j - i] : 8'd0;
      exp_q.push_back(wos_pick(w, mk, rk));
    end
  endfunction

  task automatic sh_defaults();
    for (int p = 0; p < PROGS; p++) begin
      sh_mask[p] = '1;
      sh_rank[p] = N / 2 + 1;
    end
  endtask

  task automatic cfg_write(input int a, input logic [N-1:0] mk, input int rk);
    @(negedge clk);
    cfg_we = 1'b1; cfg_addr = 2'(a); cfg_mask = mk; cfg_rank = 4'(rk);
    @(posedge clk);
    #1 cfg_we = 1'b0;
    sh_mask[a] = mk; sh_rank[a] = rk;
  endtask

  task automatic fill(input int n, input int seq);
    smp_q.delete();
    for (int i = 0; i < n; i++) smp_q.push_back(seq ? 8'(i + 1) : 8'($urandom));
  endtask

  // One burst: vmode 0 = valid every cycle, 1 = random gaps; rmode 0 = ready, 1 = toggling, 2 = random.
  // wr_it >= 0 rewrites the running program's entry on that cycle (0 = together with start).
  task automatic run_burst(input string nm, input int prog, input int n, input int vmode, input int rmode,
                           input int wr_it, input logic [N-1:0] wr_mask, input int wr_rank);
    int idx = 0, it = 0, done_it = -1, done_cnt = 0, exp_done;
    bit pend = 0, fin = 0, wrote = 0, e_err;
    logic busy_after = 1'b1, err_at_done = 1'b0;
    logic [N-1:0] load_mask = '0;
    logic [3:0] load_rank = 4'd0;
    logic [N-1:0] mk;
    int rk;
    got_q.delete(); got_it_q.delete(); sready_seen = 0; mvalid_seen = 0;
    if (wr_it == 0) begin sh_mask[prog] = wr_mask; sh_rank[prog] = wr_rank; end
    mk = sh_mask[prog]; rk = sh_rank[prog];
    e_err = (rk == 0) || (rk > $countones(mk));
    build_exp(mk, rk, n);
    exp_done = (e_err || n == 0) ? 2 : 2 + n + LAT;
    while (!fin && it < 2000) begin
      @(negedge clk);
      start = (it == 0); prog_sel = 2'(prog); num_samples = 16'(n);
      cfg_we = 1'b0;
      if (it == wr_it) begin
        cfg_we = 1'b1; cfg_addr = 2'(prog); cfg_mask = wr_mask; cfg_rank = 4'(wr_rank); wrote = 1;
      end
      if (!pend) begin
        if (idx < n && (vmode == 0 || $urandom_range(0, 2) != 0)) begin
          s_if.valid = 1'b1; s_if.data = smp_q[idx];
        end else begin
          s_if.valid = 1'b0;
        end
      end
      case (rmode)
        0: m_if.ready = 1'b1;
        1: m_if.ready = (it % 2 == 0);
        default: m_if.ready = ($urandom_range(0, 2) != 0);
      endcase
      #1;
      if (s_if.valid && s_if.ready) begin idx++; pend = 0; end
      else pend = s_if.valid;
      if (s_if.ready) sready_seen++;
      if (m_if.valid) mvalid_seen++;
      if (f_clr) begin load_mask = f_mask; load_rank = f_rank; end
      if (m_if.valid && !m_if.ready) begin
        chk({nm, "_stall_s_ready"}, 32'(s_if.ready), 32'd0);
        chk({nm, "_stall_f_en"}, 32'(f_en), 32'd0);
      end
      if (m_if.valid && m_if.ready) begin got_q.push_back(m_if.data); got_it_q.push_back(it); end
      if (done_it >= 0 && it == done_it + 1) busy_after = busy;
      if (done) begin
        done_cnt++;
        if (done_it < 0) begin done_it = it; err_at_done = cfg_err; end
      end
      if (done_it >= 0 && it > done_it && !m_if.valid) fin = 1;
      it++;
    end
    start = 1'b0; cfg_we = 1'b0; s_if.valid = 1'b0; m_if.ready = 1'b1;
    if (wrote && wr_it > 0) begin sh_mask[prog] = wr_mask; sh_rank[prog] = wr_rank; end
    chk({nm, "_timeout"}, 32'(fin), 32'd1);
    chk({nm, "_done_cnt"}, 32'(done_cnt), 32'd1);
    if (vmode == 0 && rmode == 0) chk({nm, "_done_cycle"}, 32'(done_it), 32'(exp_done));
    chk({nm, "_busy_after_done"}, 32'(busy_after), 32'd0);
    chk({nm, "_cfg_err"}, 32'(err_at_done), 32'(e_err));
    chk({nm, "_load_mask"}, 32'(load_mask), 32'(mk));
    chk({nm, "_load_rank"}, 32'(load_rank), 32'(rk));
    chk({nm, "_accepts"}, 32'(idx), (e_err || n == 0) ? 32'd0 : 32'(n));
    if (e_err) chk({nm, "_s_ready_seen"}, 32'(sready_seen), 32'd0);
    chk({nm, "_out_count"}, 32'(got_q.size()), 32'(exp_q.size()));
    for (int k = 0; k < got_q.size() && k < exp_q.size(); k++)
      chk($sformatf("%s_out%0d", nm, k), 32'(got_q[k]), 32'(exp_q[k]));
  endtask

  initial begin
    int acc;
    logic [N-1:0] mk;
    int rk;
    s_if.valid = 1'b0; s_if.data = '0; m_if.ready = 1'b1;
    sh_defaults();
    repeat (2) @(negedge clk);
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_cfg_err", 32'(cfg_err), 32'd0);
    chk("rst_m_valid", 32'(m_if.valid), 32'd0);
    chk("rst_m_data", 32'(m_if.data), 32'd0);
    chk("rst_s_ready", 32'(s_if.ready), 32'd0);
    chk("rst_f_en_clr", {30'd0, f_en, f_clr}, 32'd0);
    chk("rst_f_mask_rank", {17'd0, f_mask, f_rank}, 32'd0);
    rst = 1'b0;

    // Median over 1..16
    cfg_write(0, '1, 6);
    fill(16, 1);
    run_burst("median", 0, 16, 0, 0, -1, '0, 0);
`ifndef WOS_SEQ_PAD_EN
    if (got_q.size() == 6) begin
      chk("median_first", 32'(got_q[0]), 32'd6);
      chk("median_last", 32'(got_q[5]), 32'd11);
      chk("median_first_cycle", 32'(got_it_q[0]), 32'(2 + (N - 1) + LAT + 1));
      for (int k = 1; k < 6; k++) chk("median_consecutive", 32'(got_it_q[k] - got_it_q[k - 1]), 32'd1);
    end
`endif

    run_burst("bp", 0, 16, 0, 1, -1, '0, 0);

    cfg_write(2, 11'b11100000000, 4);
    run_burst("badcfg", 2, 16, 0, 0, -1, '0, 0);
    chk("badcfg_m_valid_seen", 32'(mvalid_seen), 32'd0);

    fill(5, 0);
    run_burst("short", 0, 5, 0, 0, -1, '0, 0);
    fill(0, 0);
    run_burst("zero", 0, 0, 0, 0, -1, '0, 0);

    // Reset in the middle of a run
    cfg_write(1, 11'b00000111111, 2);
    @(negedge clk);
    start = 1'b1; prog_sel = 2'd1; num_samples = 16'd20;
    @(negedge clk);
    start = 1'b0;
    acc = 0;
    for (int k = 0; k < 200 && acc < 7; k++) begin
      @(negedge clk);
      s_if.valid = 1'b1; s_if.data = 8'($urandom);
      #1;
      if (s_if.ready) acc++;
    end
    chk("midrst_accepts", 32'(acc), 32'd7);
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_s_ready", 32'(s_if.ready), 32'd0);
    chk("midrst_f_en", 32'(f_en), 32'd0);
    chk("midrst_m_valid", 32'(m_if.valid), 32'd0);
    chk("midrst_f_mask_rank", {17'd0, f_mask, f_rank}, 32'd0);
    @(negedge clk);
    rst = 1'b0; s_if.valid = 1'b0;
    sh_defaults();
    fill(14, 0);
    run_burst("post_rst", 1, 14, 0, 0, -1, '0, 0);

    // Table write on the same cycle as start
    fill(13, 0);
    run_burst("wr_with_start", 3, 13, 0, 0, 0, 11'b10101010101, 3);

    // Randomized runs, some with a table write landing mid-run
    for (int r = 0; r < 12; r++) begin
      int p = $urandom_range(0, PROGS - 1);
      mk = N'($urandom);
      if (mk == '0) mk = 11'd1;
      rk = $urandom_range(1, $countones(mk));
      if ($urandom_range(0, 5) == 0) rk = (r % 2 == 0) ? 0 : $countones(mk) + 1;
      cfg_write(p, mk, rk);
      fill($urandom_range(0, 30), 0);
      if (r % 3 == 0) begin
        mk = N'($urandom) | 11'd1;
        run_burst($sformatf("rand%0d", r), p, smp_q.size(), 1, 2, 5, mk, 1);
      end else begin
        run_burst($sformatf("rand%0d", r), p, smp_q.size(), 1, 2, -1, '0, 0);
      end
    end

`ifdef WOS_SEQ_PAD_EN
    cfg_write(0, '1, 11);
    smp_q.delete(); repeat (3) smp_q.push_back(8'd9);
    run_burst("pad_max", 0, 3, 0, 0, -1, '0, 0);
    for (int k = 0; k < 3 && k < got_q.size(); k++) chk("pad_max_val", 32'(got_q[k]), 32'd9);
    cfg_write(0, '1, 1);
    run_burst("pad_min", 0, 3, 0, 0, -1, '0, 0);
    for (int k = 0; k < 3 && k < got_q.size(); k++) chk("pad_min_val", 32'(got_q[k]), 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/wos_filter_sequencer.md
Name: wos_filter_sequencer

Overview:
- Run-time controller for the masked rank-order filter core.
- Holds a small table of filter programs (mask plus rank) and runs one program over a burst of `num_samples` input samples.
- Moves samples from a valid/ready input stream into the core through a clock-enable, and hides window warm-up and core latency.
- Presents results on a valid/ready output stream.

Parameters:
- N, 11, filter window taps (mask width)
- DATA_BITS, 8, sample width
- PROGS, 4, program table depth
- LAT, 2, core latency in enabled cycles (sample on f_in to result on f_out)
- CNT_BITS, 16, sample counter width

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- cfg_we  in  1  program table write strobe
- cfg_addr  in  clog2(PROGS)  table entry to write
- cfg_mask  in  N  tap mask to write
- cfg_rank  in  clog2(N+1)  rank to write; 1 = smallest masked tap
- start  in  1  start a run; sampled only in IDLE
- prog_sel  in  clog2(PROGS)  program used by the run
- num_samples  in  CNT_BITS  input samples in the run
- busy  out  1  high whenever state is not IDLE
- done  out  1  one-cycle pulse at end of run
- cfg_err  out  1  selected program invalid; held until next start
- s_data  in  DATA_BITS  input sample
- s_valid  in  1  input valid
- s_ready  out  1  input ready
- f_in  out  DATA_BITS  sample to core
- f_mask  out  N  active mask to core
- f_rank  out  clog2(N+1)  active rank to core
- f_en  out  1  core clock-enable; all core registers advance only when high
- f_clr  out  1  one-cycle synchronous clear of the core window (all taps 0)
- f_out  in  DATA_BITS  core result
- m_data  out  DATA_BITS  output sample
- m_valid  out  1  output valid
- m_ready  in  1  output ready

Behaviour:
- Reset:
  - state IDLE; all outputs 0.
  - Every table entry becomes mask all-ones, rank N/2+1 (6 for N=11).
  - Reset mid-run aborts immediately; there is no done pulse and pending outputs are lost.
- Table:
  - Write on clk when cfg_we is high, in any state.
  - The running program is latched in LOAD, so a write during a run affects later runs only.
- States:
  - IDLE: start=1 -> LOAD. Latch prog_sel and num_samples; clear cfg_err.
  - LOAD (1 cycle):
    - Drive f_mask/f_rank from the table and pulse f_clr.
    - If rank = 0 or rank > popcount(mask): set cfg_err, go to DONE.
    - Else if num_samples = 0: go to DONE.
    - Otherwise go to RUN.
  - RUN:
    - adv = s_valid and (not m_valid or m_ready).
    - s_ready = f_en = adv; f_in = s_data.
    - When the last sample is accepted (in_cnt = num_samples-1 with adv) -> DRAIN.
  - DRAIN:
    - adv = not m_valid or m_ready; f_en = adv; f_in = 0; s_ready = 0.
    - After LAT adv cycles -> DONE.
  - DONE: done=1 for one cycle, then IDLE. m_valid may still be pending and is consumed normally.
- Tag pipeline: LAT-deep shift register advanced by f_en.
  - Entry tag = 1 for an accepted sample with index >= N-1; 0 for bubbles and warm-up samples.
- Output register:
  - On f_en with tag output = 1: m_data <= f_out, m_valid <= 1.
  - Otherwise m_valid clears on m_ready.
  - Throughput is 1 sample/cycle while m_ready=1; no output is ever dropped or duplicated.
- Counting:
  - Outputs per run = max(0, num_samples-N+1).
  - in_cnt resets in LOAD and is CNT_BITS wide; no wrap is possible because num_samples fits.
- Simultaneous events: start while busy is ignored; cfg_we together with start to the same entry lets the run use the new value.

Optional Feature:
- WOS_SEQ_PAD_EN defined: every accepted sample is tagged valid. Outputs per run = num_samples; warm-up outputs use the zero-filled window left by f_clr.
- Not defined: warm-up outputs are suppressed as above.

Test Plan:
- Median run:
  - Stimulus: prog0 mask all-ones, rank 6, num_samples 16; samples 1..16 back-to-back; m_ready=1.
  - Response: m_data 6,7,8,9,10,11 on consecutive cycles; done once; busy low the cycle after done.
- Backpressure:
  - Stimulus: same run with m_ready toggling 1,0,1,0.
  - Response: identical output sequence; s_ready and f_en low in every cycle with m_valid=1 and m_ready=0.
- Bad config:
  - Stimulus: mask 11'b11100000000, rank 4.
  - Response: cfg_err=1 and done two cycles after start; s_ready never high; no m_valid.
- Short burst:
  - Stimulus: num_samples 5, mask all-ones.
  - Response: zero outputs; done after 5 accepts plus LAT drain cycles.
- Reset mid-RUN:
  - Stimulus: rst pulse after 7 accepts.
  - Response: all outputs 0 asynchronously and table at defaults. A new start with prog_sel 1 then runs with mask all-ones, rank 6.
- PAD mode (WOS_SEQ_PAD_EN):
  - Stimulus: samples 9,9,9, mask all-ones.
  - Response: rank 11 gives 9,9,9; rank 1 gives 0,0,0.
